// File: rtl/cache_controller.sv
// cache_controller: direct-mapped, write-back, write-allocate cache controller
// with 64 lines. It holds the tag, valid and dirty arrays. The data array is
// external and is steered through data_we, data_refill and data_index.
//
// Ports:
//   clk, rst       - clock; synchronous active-high reset
//   cpu_req_valid  - CPU request present
//   cpu_req_rw     - 1 = write, 0 = read
//   cpu_tag        - request tag (address[31:8])
//   cpu_index      - request line index (address[7:2])
//   cpu_req_ready  - block can accept a request (IDLE only)
//   cpu_done       - one-cycle completion pulse
//   hit, miss      - one-cycle first-lookup result pulses
//   mem_req_valid  - memory request active
//   mem_req_rw     - 1 = write-back, 0 = refill read
//   mem_req_addr   - block-aligned address {tag, index, 2'b00}
//   mem_ack        - memory completed the current request
//   data_we        - write CPU word into the data array at data_index
//   data_refill    - load the returned memory block at data_index
//   data_index     - latched request index
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  input  logic        cpu_req_rw,
  input  logic [23:0] cpu_tag,
  input  logic [5:0]  cpu_index,
  output logic        cpu_req_ready,
  output logic        cpu_done,
  output logic        hit,
  output logic        miss,
  output logic        mem_req_valid,
  output logic        mem_req_rw,
  output logic [31:0] mem_req_addr,
  input  logic        mem_ack,
  output logic        data_we,
  output logic        data_refill,
  output logic [5:0]  data_index
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } state_t;

  state_t      state, state_n;

  logic [23:0] tag_arr [64];
  logic [63:0] valid_arr;
  logic [63:0] dirty_arr;

  logic [23:0] req_tag;
  logic [5:0]  req_index;
  logic        req_rw;
  logic        first_lookup;

  logic        lookup_hit;

  assign lookup_hit = valid_arr[req_index] && (tag_arr[req_index] == req_tag);
  assign data_index = req_index;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    cpu_req_ready = 1'b0;
    cpu_done      = 1'b0;
    hit           = 1'b0;
    miss          = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    data_we       = 1'b0;
    data_refill   = 1'b0;
    case (state)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) state_n = COMPARE;
      end
      COMPARE: begin
        if (lookup_hit) begin
          cpu_done = 1'b1;
          hit      = first_lookup;
          data_we  = req_rw;
          state_n  = IDLE;
        end else begin
          miss = 1'b1;
          // Victim must be written back only if it holds modified data.
          if (valid_arr[req_index] && dirty_arr[req_index]) state_n = WRITE_BACK;
          else                                               state_n = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {tag_arr[req_index], req_index, 2'b00};
        if (mem_ack) state_n = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = {req_tag, req_index, 2'b00};
        data_refill   = mem_ack;
        if (mem_ack) state_n = COMPARE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_arr    <= '0;
      dirty_arr    <= '0;
      req_tag      <= '0;
      req_index    <= '0;
      req_rw       <= 1'b0;
      first_lookup <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            req_tag      <= cpu_tag;
            req_index    <= cpu_index;
            req_rw       <= cpu_req_rw;
            first_lookup <= 1'b1;
          end
        end
        COMPARE: begin
          if (lookup_hit && req_rw) dirty_arr[req_index] <= 1'b1;
        end
        WRITE_BACK: begin
          if (mem_ack) dirty_arr[req_index] <= 1'b0;
        end
        ALLOCATE: begin
          if (mem_ack) begin
            valid_arr[req_index] <= 1'b1;
            dirty_arr[req_index] <= 1'b0;
            first_lookup         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag storage needs no reset: an entry is only meaningful once its valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && state == ALLOCATE && mem_ack) tag_arr[req_index] <= req_tag;
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_rw;
  logic [23:0] cpu_tag;
  logic [5:0]  cpu_index;
  logic        cpu_req_ready;
  logic        cpu_done;
  logic        hit;
  logic        miss;
  logic        mem_req_valid;
  logic        mem_req_rw;
  logic [31:0] mem_req_addr;
  logic        mem_ack;
  logic        data_we;
  logic        data_refill;
  logic [5:0]  data_index;

  int unsigned n_pass;
  int unsigned n_total;

  cache_controller dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_rw    (cpu_req_rw),
    .cpu_tag       (cpu_tag),
    .cpu_index     (cpu_index),
    .cpu_req_ready (cpu_req_ready),
    .cpu_done      (cpu_done),
    .hit           (hit),
    .miss          (miss),
    .mem_req_valid (mem_req_valid),
    .mem_req_rw    (mem_req_rw),
    .mem_req_addr  (mem_req_addr),
    .mem_ack       (mem_ack),
    .data_we       (data_we),
    .data_refill   (data_refill),
    .data_index    (data_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic request(input logic rw, input logic [23:0] tag, input logic [5:0] idx);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = rw;
    cpu_tag       = tag;
    cpu_index     = idx;
  endtask

  int unsigned cyc;
  int unsigned alloc_cycles;
  int unsigned miss_seen;
  bit          done_seen;

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst           = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_rw    = 1'b0;
    cpu_tag       = '0;
    cpu_index     = '0;
    mem_ack       = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_ready", {31'd0, cpu_req_ready}, 32'd1);
    chk("rst_memv", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_addr", mem_req_addr, 32'd0);
    chk("rst_pulses", {27'd0, cpu_done, hit, miss, data_we, data_refill}, 32'd0);
    chk("rst_didx", {26'd0, data_index}, 32'd0);
    rst = 1'b0;

    // Cold read miss, ack in the 3rd ALLOCATE cycle
    step();
    request(1'b0, 24'h000012, 6'd5);
    step();
    cpu_req_valid = 1'b0;
    chk("cold_miss", {30'd0, hit, miss}, 32'd1);
    chk("cold_cmp_memv", {31'd0, mem_req_valid}, 32'd0);
    chk("cold_cmp_ready", {31'd0, cpu_req_ready}, 32'd0);
    step();
    chk("cold_al1_memv", {30'd0, mem_req_valid, mem_req_rw}, 32'd2);
    chk("cold_al1_addr", mem_req_addr, 32'h00001214);
    chk("cold_al1_refill", {31'd0, data_refill}, 32'd0);
    step();
    chk("cold_al2_addr", mem_req_addr, 32'h00001214);
    step();
    mem_ack = 1'b1;
    #1;
    chk("cold_al3_refill", {30'd0, data_refill, mem_req_valid}, 32'd3);
    chk("cold_al3_didx", {26'd0, data_index}, 32'd5);
    step();
    mem_ack = 1'b0;
    chk("cold_done", {29'd0, cpu_done, hit, miss}, 32'd4);
    step();
    chk("cold_idle", {31'd0, cpu_req_ready}, 32'd1);

    // Read hit
    request(1'b0, 24'h000012, 6'd5);
    step();
    cpu_req_valid = 1'b0;
    chk("rhit_pulse", {29'd0, cpu_done, hit, miss}, 32'd6);
    chk("rhit_memv", {30'd0, mem_req_valid, data_we}, 32'd0);
    step();
    chk("rhit_ready", {31'd0, cpu_req_ready}, 32'd1);

    // Write hit marks line dirty
    request(1'b1, 24'h000012, 6'd5);
    step();
    cpu_req_valid = 1'b0;
    chk("whit_pulse", {28'd0, cpu_done, hit, miss, data_we}, 32'hD);
    chk("whit_didx", {26'd0, data_index}, 32'd5);
    step();

    // Conflicting read evicts dirty line
    request(1'b0, 24'h0000AB, 6'd5);
    step();
    cpu_req_valid = 1'b0;
    chk("evict_miss", {30'd0, hit, miss}, 32'd1);
    step();
    chk("wb_req", {30'd0, mem_req_valid, mem_req_rw}, 32'd3);
    chk("wb_addr", mem_req_addr, 32'h00001214);
    chk("wb_refill", {31'd0, data_refill}, 32'd0);
    mem_ack = 1'b1;
    step();
    chk("evict_al_req", {30'd0, mem_req_valid, mem_req_rw}, 32'd2);
    chk("evict_al_addr", mem_req_addr, 32'h0000AB14);
    chk("evict_al_refill", {31'd0, data_refill}, 32'd1);
    step();
    mem_ack = 1'b0;
    chk("evict_done", {29'd0, cpu_done, hit, miss}, 32'd4);
    step();

    // Zero-wait memory on a clean miss
    mem_ack = 1'b1;
    request(1'b0, 24'h000034, 6'd7);
    alloc_cycles = 0;
    miss_seen    = 0;
    done_seen    = 1'b0;
    cyc          = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      cpu_req_valid = 1'b0;
      if (mem_req_valid) alloc_cycles++;
      if (miss) miss_seen++;
      if (cpu_done) begin
        cyc       = k;
        done_seen = 1'b1;
        break;
      end
    end
    mem_ack = 1'b0;
    chk("zw_done_seen", {31'd0, done_seen}, 32'd1);
    chk("zw_latency", cyc, 32'd3);
    chk("zw_alloc_cycles", alloc_cycles, 32'd1);
    chk("zw_miss_count", miss_seen, 32'd1);
    step();

    // Reset during the 2nd ALLOCATE cycle
    request(1'b0, 24'h000056, 6'd9);
    step();
    cpu_req_valid = 1'b0;
    chk("rma_miss", {31'd0, miss}, 32'd1);
    step();
    chk("rma_al1", {31'd0, mem_req_valid}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rma_idle", {29'd0, cpu_req_ready, mem_req_valid, cpu_done}, 32'd4);
    request(1'b0, 24'h000056, 6'd9);
    step();
    cpu_req_valid = 1'b0;
    chk("rma_remiss", {29'd0, cpu_done, hit, miss}, 32'd1);
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("rma_done", {29'd0, cpu_done, hit, miss}, 32'd4);
    step();

    // Back-pressure: tag changes while busy must not be picked up
    request(1'b0, 24'h000077, 6'd10);
    step();
    cpu_tag = 24'h000088;
    chk("bp_miss", {31'd0, miss}, 32'd1);
    step();
    cpu_tag = 24'h000099;
    chk("bp_addr", mem_req_addr, 32'h00007728);
    mem_ack = 1'b1;
    step();
    mem_ack       = 1'b0;
    cpu_req_valid = 1'b0;
    chk("bp_done", {29'd0, cpu_done, hit, miss}, 32'd4);
    step();
    request(1'b0, 24'h000077, 6'd10);
    step();
    cpu_req_valid = 1'b0;
    chk("bp_rehit", {29'd0, cpu_done, hit, miss}, 32'd6);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The block SHALL use one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 cpu_req_valid  input  1  CPU request present.
REQ-005 cpu_req_rw  input  1  1 = write, 0 = read.
REQ-006 cpu_tag  input  24  request tag (address[31:8]).
REQ-007 cpu_index  input  6  request line index (address[7:2]).
REQ-008 cpu_req_ready  output  1  block can accept a request.
REQ-009 cpu_done  output  1  one-cycle pulse when the request completes.
REQ-010 hit  output  1  one-cycle pulse for a first-lookup hit.
REQ-011 miss  output  1  one-cycle pulse for a first-lookup miss.
REQ-012 mem_req_valid  output  1  memory request active.
REQ-013 mem_req_rw  output  1  1 = write-back, 0 = refill read.
REQ-014 mem_req_addr  output  32  block-aligned address {tag, index, 2'b00}.
REQ-015 mem_ack  input  1  memory completed the current request.
REQ-016 data_we  output  1  write CPU word into the data array at data_index.
REQ-017 data_refill  output  1  load the returned memory block into the data array at data_index.
REQ-018 data_index  output  6  data-array line select; equals the latched request index.

Function
REQ-019 The block SHALL hold internal arrays of 64 entries: tag (24 bits), valid (1 bit), and dirty (1 bit).
REQ-020 The FSM SHALL have four states: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
REQ-021 In IDLE, cpu_req_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-022 When cpu_req_valid && cpu_req_ready, the block SHALL latch cpu_tag, cpu_index and cpu_req_rw, set first_lookup=1, and go to COMPARE.
REQ-023 cpu_* inputs SHALL be ignored whenever cpu_req_ready=0.
REQ-024 COMPARE hit condition: valid[idx] && tag[idx]==latched tag.
REQ-025 COMPARE on hit: assert cpu_done; assert hit only if first_lookup; if rw=1, also assert data_we and set dirty[idx]=1; then go to IDLE.
REQ-026 Hit latency SHALL be: cpu_done in the cycle after acceptance, and cpu_req_ready=1 one cycle later.
REQ-027 COMPARE on miss (only reachable with first_lookup=1): assert miss for one cycle.
REQ-028 On a miss with valid[idx] && dirty[idx], the block SHALL go to WRITE_BACK; otherwise it SHALL go to ALLOCATE.
REQ-029 WRITE_BACK outputs: mem_req_valid=1, mem_req_rw=1, mem_req_addr={tag[idx], idx, 2'b00}, all held stable until mem_ack.
REQ-030 WRITE_BACK on mem_ack: clear dirty[idx] and go to ALLOCATE.
REQ-031 ALLOCATE outputs: mem_req_valid=1, mem_req_rw=0, mem_req_addr={latched tag, idx, 2'b00}, all held until mem_ack.
REQ-032 ALLOCATE on mem_ack: assert data_refill; set tag[idx]=latched tag, valid[idx]=1, dirty[idx]=0; clear first_lookup; go to COMPARE.
REQ-033 The re-compare after ALLOCATE SHALL hit and complete per REQ-025, with hit=0.
REQ-034 mem_ack SHALL be accepted in the first cycle mem_req_valid is asserted (zero-wait memory), and SHALL be ignored in IDLE and COMPARE.
REQ-035 hit, miss, cpu_done, data_we and data_refill SHALL never be asserted simultaneously with mem_req_valid, except data_refill in the ALLOCATE ack cycle.
REQ-036 hit and miss SHALL be mutually exclusive; exactly one SHALL pulse per accepted request.

Reset
REQ-037 On rst=1 at a clock edge, the state SHALL become IDLE and all valid and dirty bits SHALL clear; tag contents are don't-care.
REQ-038 Output values during and after reset: cpu_req_ready=1; all other outputs 0; mem_req_addr=0.
REQ-039 Reset asserted mid-WRITE_BACK or mid-ALLOCATE SHALL drop mem_req_valid in the following cycle, and the in-flight request SHALL be abandoned with no cpu_done.

Verification
REQ-040 Cold read: after reset, read tag=0x000012, index=5, mem_ack in the 3rd ALLOCATE cycle -> miss pulse; mem_req_addr=0x00001214, rw=0; data_refill; then cpu_done with hit=0.
REQ-041 Read hit: repeat REQ-040's request -> hit=1 and cpu_done in the cycle after acceptance; mem_req_valid stays 0.
REQ-042 Write hit then evict: write tag=0x000012, index=5 (hit, data_we, dirty set); then read tag=0x0000AB, index=5 -> WRITE_BACK with addr 0x00001214, rw=1; then ALLOCATE with addr 0x0000AB14, rw=0; then cpu_done.
REQ-043 Zero-wait memory: mem_ack tied to 1 on a clean miss -> ALLOCATE lasts exactly one cycle; cpu_done 3 cycles after acceptance.
REQ-044 Reset mid-ALLOCATE: rst pulsed during the 2nd ALLOCATE cycle -> next cycle IDLE, mem_req_valid=0, no cpu_done; the same address then misses again.
REQ-045 Back-pressure: cpu_req_valid held high with changing tag while busy -> only the tag present at the accept cycle is used.
